// File: rtl/hack_alu_pkg.sv
// rtl/hack_alu_pkg.sv - shared width, control-bit indices and canonical function codes for hack_alu
package hack_alu_pkg;

   localparam int W = 16;

   // Bit positions inside the packed control word {zx, nx, zy, ny, f, no}
   localparam int CTL_ZX = 5;
   localparam int CTL_NX = 4;
   localparam int CTL_ZY = 3;
   localparam int CTL_NY = 2;
   localparam int CTL_F  = 1;
   localparam int CTL_NO = 0;

   localparam logic [5:0] C_ZERO    = 6'b101010;
   localparam logic [5:0] C_ONE     = 6'b111111;
   localparam logic [5:0] C_NEG1    = 6'b111010;
   localparam logic [5:0] C_X       = 6'b001100;
   localparam logic [5:0] C_Y       = 6'b110000;
   localparam logic [5:0] C_NOT_X   = 6'b001101;
   localparam logic [5:0] C_NEG_X   = 6'b001111;
   localparam logic [5:0] C_X_INC   = 6'b011111;
   localparam logic [5:0] C_X_ADD_Y = 6'b000010;
   localparam logic [5:0] C_X_SUB_Y = 6'b010011;
   localparam logic [5:0] C_Y_SUB_X = 6'b000111;
   localparam logic [5:0] C_X_AND_Y = 6'b000000;
   localparam logic [5:0] C_X_OR_Y  = 6'b010101;

endpackage

// File: rtl/hack_alu_pre.sv
// rtl/hack_alu_pre.sv - operand preprocessor: optional zeroing followed by optional bitwise inversion
module hack_alu_pre
   import hack_alu_pkg::*;
(
   input  logic [W-1:0] data_i,
   input  logic         zero_i,
   input  logic         neg_i,
   output logic [W-1:0] data_o
);

   logic [W-1:0] zeroed;

   assign zeroed = zero_i ? '0 : data_i;
   assign data_o = neg_i ? ~zeroed : zeroed;

endmodule

// File: rtl/hack_alu.sv
// rtl/hack_alu.sv - Hack 16-bit ALU with combinational result/flags and a clock-enabled result register
// Carry/overflow status ports and logic exist only when HACK_ALU_STATUS_EN is defined.
module hack_alu
   import hack_alu_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   input  logic         zx,
   input  logic         nx,
   input  logic         zy,
   input  logic         ny,
   input  logic         f,
   input  logic         no,
   input  logic         en,
   output logic [W-1:0] out,
   output logic         zr,
   output logic         ng,
   output logic [W-1:0] out_r,
   output logic         zr_r,
   output logic         ng_r
`ifdef HACK_ALU_STATUS_EN
   ,
   output logic         cy,
   output logic         ov,
   output logic         cy_r,
   output logic         ov_r
`endif
);

   logic [5:0]   ctl;
   logic [W-1:0] xb;
   logic [W-1:0] yb;
   logic [W-1:0] sum;
   logic [W-1:0] res;

   logic [W-1:0] out_q, out_d;
   logic         zr_q,  zr_d;
   logic         ng_q,  ng_d;

   assign ctl = {zx, nx, zy, ny, f, no};

   hack_alu_pre u_pre_x (
      .data_i (x),
      .zero_i (ctl[CTL_ZX]),
      .neg_i  (ctl[CTL_NX]),
      .data_o (xb)
   );

   hack_alu_pre u_pre_y (
      .data_i (y),
      .zero_i (ctl[CTL_ZY]),
      .neg_i  (ctl[CTL_NY]),
      .data_o (yb)
   );

`ifdef HACK_ALU_STATUS_EN
   logic [W:0] sum_full;
   logic       cy_q, cy_d;
   logic       ov_q, ov_d;

   assign sum_full = {1'b0, xb} + {1'b0, yb};
   assign sum      = sum_full[W-1:0];
   // Status reflects the adder before the output inversion and is masked in AND mode.
   assign cy = ctl[CTL_F] & sum_full[W];
   assign ov = ctl[CTL_F] & (xb[W-1] == yb[W-1]) & (sum[W-1] != xb[W-1]);
`else
   assign sum = xb + yb;
`endif

   assign res = ctl[CTL_F] ? sum : (xb & yb);
   assign out = ctl[CTL_NO] ? ~res : res;
   assign zr  = (out == '0);
   assign ng  = out[W-1];

   always_comb begin
      out_d = out_q;
      zr_d  = zr_q;
      ng_d  = ng_q;
`ifdef HACK_ALU_STATUS_EN
      cy_d  = cy_q;
      ov_d  = ov_q;
`endif
      if (en) begin
         out_d = out;
         zr_d  = zr;
         ng_d  = ng;
`ifdef HACK_ALU_STATUS_EN
         cy_d  = cy;
         ov_d  = ov;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q <= '0;
         zr_q  <= 1'b1;
         ng_q  <= 1'b0;
`ifdef HACK_ALU_STATUS_EN
         cy_q  <= 1'b0;
         ov_q  <= 1'b0;
`endif
      end else begin
         out_q <= out_d;
         zr_q  <= zr_d;
         ng_q  <= ng_d;
`ifdef HACK_ALU_STATUS_EN
         cy_q  <= cy_d;
         ov_q  <= ov_d;
`endif
      end
   end

   assign out_r = out_q;
   assign zr_r  = zr_q;
   assign ng_r  = ng_q;
`ifdef HACK_ALU_STATUS_EN
   assign cy_r  = cy_q;
   assign ov_r  = ov_q;
`endif

endmodule

// File: tb/tb_hack_alu.sv
// tb/tb_hack_alu.sv - directed self-checking bench for hack_alu (status checks active with HACK_ALU_STATUS_EN)
module tb_hack_alu;
   import hack_alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [15:0] x;
   logic [15:0] y;
   logic [5:0]  code;
   logic [15:0] out;
   logic        zr;
   logic        ng;
   logic [15:0] out_r;
   logic        zr_r;
   logic        ng_r;
`ifdef HACK_ALU_STATUS_EN
   logic        cy;
   logic        ov;
   logic        cy_r;
   logic        ov_r;
`endif

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   hack_alu dut (
      .clk   (clk),
      .rst   (rst),
      .x     (x),
      .y     (y),
      .zx    (code[5]),
      .nx    (code[4]),
      .zy    (code[3]),
      .ny    (code[2]),
      .f     (code[1]),
      .no    (code[0]),
      .en    (en),
      .out   (out),
      .zr    (zr),
      .ng    (ng),
      .out_r (out_r),
      .zr_r  (zr_r),
      .ng_r  (ng_r)
`ifdef HACK_ALU_STATUS_EN
      ,
      .cy    (cy),
      .ov    (ov),
      .cy_r  (cy_r),
      .ov_r  (ov_r)
`endif
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference equations: returns {cy, ov, out}
   function automatic logic [17:0] model(input logic [5:0] c, input logic [15:0] a, input logic [15:0] b);
      logic [15:0] xa, xb2, ya, yb2, r;
      logic [16:0] s;
      logic        c_o, v_o;
      xa  = c[5] ? 16'h0000 : a;
      xb2 = c[4] ? ~xa : xa;
      ya  = c[3] ? 16'h0000 : b;
      yb2 = c[2] ? ~ya : ya;
      s   = {1'b0, xb2} + {1'b0, yb2};
      r   = c[1] ? s[15:0] : (xb2 & yb2);
      c_o = c[1] & s[16];
      v_o = c[1] & (xb2[15] == yb2[15]) & (s[15] != xb2[15]);
      return {c_o, v_o, (c[0] ? ~r : r)};
   endfunction

   task automatic apply(input logic [5:0] c, input logic [15:0] a, input logic [15:0] b);
      @(negedge clk);
      code = c;
      x    = a;
      y    = b;
      #1;
   endtask

   logic [15:0] px [8];
   logic [15:0] py [8];
   logic [17:0] m;

   initial begin
      px[0] = 16'h0000; py[0] = 16'h0000;
      px[1] = 16'h0001; py[1] = 16'h0001;
      px[2] = 16'hFFFF; py[2] = 16'h0001;
      px[3] = 16'h1234; py[3] = 16'h5678;
      px[4] = 16'h8000; py[4] = 16'h0001;
      px[5] = 16'h7FFF; py[5] = 16'h0001;
      px[6] = 16'hAAAA; py[6] = 16'h5555;
      px[7] = 16'hF0F0; py[7] = 16'h0F0F;

      rst  = 1'b1;
      en   = 1'b0;
      code = C_ZERO;
      x    = 16'h0000;
      y    = 16'h0000;

      // Register reset state
      @(posedge clk);
      #1;
      chk("rst out_r", out_r, 16'h0000);
      chk("rst zr_r", zr_r, 1'b1);
      chk("rst ng_r", ng_r, 1'b0);
`ifdef HACK_ALU_STATUS_EN
      chk("rst cy_r", cy_r, 1'b0);
      chk("rst ov_r", ov_r, 1'b0);
`endif
      @(negedge clk);
      rst = 1'b0;

      // Exhaustive control-code sweep against the reference equations
      for (int c = 0; c < 64; c++) begin
         for (int p = 0; p < 8; p++) begin
            apply(6'(c), px[p], py[p]);
            m = model(6'(c), px[p], py[p]);
            chk($sformatf("sweep out c=%b x=%h y=%h", 6'(c), px[p], py[p]), out, m[15:0]);
            chk($sformatf("sweep zr c=%b x=%h y=%h", 6'(c), px[p], py[p]), zr, (m[15:0] == 16'h0000));
            chk($sformatf("sweep ng c=%b x=%h y=%h", 6'(c), px[p], py[p]), ng, m[15]);
`ifdef HACK_ALU_STATUS_EN
            chk($sformatf("sweep cy c=%b x=%h y=%h", 6'(c), px[p], py[p]), cy, m[17]);
            chk($sformatf("sweep ov c=%b x=%h y=%h", 6'(c), px[p], py[p]), ov, m[16]);
`endif
         end
      end

      // Hand-computed boundary vectors
      apply(C_X_ADD_Y, 16'h7FFF, 16'h0001);
      chk("add ovf out", out, 16'h8000);
      chk("add ovf zr", zr, 1'b0);
      chk("add ovf ng", ng, 1'b1);
`ifdef HACK_ALU_STATUS_EN
      chk("add ovf ov", ov, 1'b1);
      chk("add ovf cy", cy, 1'b0);
`endif
      apply(C_X_ADD_Y, 16'hFFFF, 16'h0001);
      chk("add wrap out", out, 16'h0000);
      chk("add wrap zr", zr, 1'b1);
`ifdef HACK_ALU_STATUS_EN
      chk("add wrap cy", cy, 1'b1);
      chk("add wrap ov", ov, 1'b0);
`endif
      apply(C_X_SUB_Y, 16'h1234, 16'h5678);
      chk("x-y out", out, 16'hBBBC);
      chk("x-y ng", ng, 1'b1);
      apply(C_Y_SUB_X, 16'h1234, 16'h5678);
      chk("y-x out", out, 16'h4444);
      chk("y-x ng", ng, 1'b0);
      apply(C_X_AND_Y, 16'hAAAA, 16'h5555);
      chk("and out", out, 16'h0000);
      chk("and zr", zr, 1'b1);
      apply(C_X_OR_Y, 16'hAAAA, 16'h5555);
      chk("or out", out, 16'hFFFF);
      chk("or ng", ng, 1'b1);
      apply(C_NEG_X, 16'h0001, 16'h0000);
      chk("neg x out", out, 16'hFFFF);
      apply(C_X_INC, 16'h7FFF, 16'h0000);
      chk("x+1 out", out, 16'h8000);

      // Register load, hold and reset priority
      @(negedge clk);
      rst = 1'b1;
      en  = 1'b0;
      @(posedge clk);
      #1;
      chk("reg rst out_r", out_r, 16'h0000);
      chk("reg rst zr_r", zr_r, 1'b1);
      chk("reg rst ng_r", ng_r, 1'b0);

      @(negedge clk);
      rst  = 1'b0;
      en   = 1'b1;
      code = C_ONE;
      x    = 16'h1234;
      y    = 16'h5678;
      @(posedge clk);
      #1;
      chk("load out_r", out_r, 16'h0001);
      chk("load zr_r", zr_r, 1'b0);
      chk("load ng_r", ng_r, 1'b0);
`ifdef HACK_ALU_STATUS_EN
      chk("load cy_r", cy_r, 1'b1);
      chk("load ov_r", ov_r, 1'b0);
`endif

      @(negedge clk);
      en   = 1'b0;
      code = C_NEG1;
      #1;
      chk("hold comb out", out, 16'hFFFF);
      @(posedge clk);
      #1;
      chk("hold out_r", out_r, 16'h0001);
      chk("hold zr_r", zr_r, 1'b0);
      chk("hold comb out after edge", out, 16'hFFFF);
      chk("hold comb ng", ng, 1'b1);

      @(negedge clk);
      rst = 1'b1;
      en  = 1'b1;
      @(posedge clk);
      #1;
      chk("rst prio out_r", out_r, 16'h0000);
      chk("rst prio zr_r", zr_r, 1'b1);
      chk("rst prio ng_r", ng_r, 1'b0);
      chk("rst comb out", out, 16'hFFFF);
`ifdef HACK_ALU_STATUS_EN
      chk("rst prio cy_r", cy_r, 1'b0);
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
